// File: rtl/text_console_buffer_pkg.sv
// Shared definitions for the text console buffer: control codes, printable
// range and the write-side state encoding.
package console_pkg;

    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_CR = 8'h0D;
    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_FF = 8'h0C;

    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL,
        ST_IDLE,
        ST_CLEAR_ROW
    } console_state_e;

endpackage

// File: rtl/text_console_buffer_if.sv
// Character stream into the console buffer: valid/ready handshake plus data.
interface text_console_buffer_if #(
    parameter int CHAR_W = 8
) ();
    logic              char_valid;
    logic              char_ready;
    logic [CHAR_W-1:0] char_data;

    modport master (output char_valid, output char_data, input char_ready);
    modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/text_console_buffer_ram.sv
// Simple dual-port cell store: one write port, one registered read port,
// no reset on the array so it maps onto block RAM.
module text_cell_ram #(
    parameter int DEPTH  = 2000,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read and write share the edge, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_console_buffer.sv
// Character-cell console: streaming writes with cursor, control codes, line
// wrap and circular-offset scrolling, plus a registered logical read port.
module text_console_buffer
    import console_pkg::*;
#(
    parameter int               COLS   = 80,
    parameter int               ROWS   = 25,
    parameter int               CHAR_W = 8,
    parameter logic [CHAR_W-1:0] BLANK = CHAR_W'(8'h20),
    parameter int               COL_W  = $clog2(COLS),
    parameter int               ROW_W  = $clog2(ROWS)
) (
    input  logic                clk,
    input  logic                reset,
    text_console_buffer_if.slave chr,
    input  logic [COL_W-1:0]    rd_x,
    input  logic [ROW_W-1:0]    rd_y,
    output logic [CHAR_W-1:0]   rd_char,
    output logic [COL_W-1:0]    cursor_x,
    output logic [ROW_W-1:0]    cursor_y,
    output logic                busy,
    output logic                scroll_pulse
);

    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = $clog2(CELLS);

    localparam logic [CHAR_W-1:0] K_LF  = CHAR_W'(CC_LF);
    localparam logic [CHAR_W-1:0] K_CR  = CHAR_W'(CC_CR);
    localparam logic [CHAR_W-1:0] K_BS  = CHAR_W'(CC_BS);
    localparam logic [CHAR_W-1:0] K_FF  = CHAR_W'(CC_FF);
    localparam logic [CHAR_W-1:0] K_PLO = CHAR_W'(PRINT_LO);
    localparam logic [CHAR_W-1:0] K_PHI = CHAR_W'(PRINT_HI);

    function automatic logic [ROW_W-1:0] physRow(input logic [ROW_W-1:0] logical,
                                                 input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, logical} + {1'b0, top};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cellAddr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    console_state_e    state_q;
    logic [COL_W-1:0]  cursorX_q;
    logic [ROW_W-1:0]  cursorY_q;
    logic [ROW_W-1:0]  top_q;
    logic [ADDR_W-1:0] sweep_q;
    logic [ADDR_W-1:0] rowBase_q;
    logic              ready_q;
    logic              busy_q;
    logic              scroll_q;
    logic              rdOob_q;

    logic              accept, isPrint, isLF, isCR, isBS, isFF, lastCol, doNewline;
    logic [ROW_W-1:0]  curRow;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [CHAR_W-1:0] wrData;
    logic              rdOob;
    logic [ADDR_W-1:0] rdAddr;
    logic [CHAR_W-1:0] ramData;

    assign accept    = chr.char_valid && ready_q;
    assign isPrint   = (chr.char_data >= K_PLO) && (chr.char_data <= K_PHI);
    assign isLF      = (chr.char_data == K_LF);
    assign isCR      = (chr.char_data == K_CR);
    assign isBS      = (chr.char_data == K_BS);
    assign isFF      = (chr.char_data == K_FF);
    assign lastCol   = (cursorX_q == COL_W'(COLS - 1));
    assign doNewline = isLF || (isPrint && lastCol);
    assign curRow    = physRow(cursorY_q, top_q);

    always_comb begin
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = BLANK;
        case (state_q)
            ST_CLEAR_ALL: begin
                wrEn   = 1'b1;
                wrAddr = sweep_q;
            end
            ST_CLEAR_ROW: begin
                wrEn   = 1'b1;
                wrAddr = rowBase_q + sweep_q;
            end
            default: begin
                if (accept && isPrint) begin
                    wrEn   = 1'b1;
                    wrAddr = cellAddr(curRow, cursorX_q);
                    wrData = chr.char_data;
                end else if (accept && isBS && cursorX_q != '0) begin
                    wrEn   = 1'b1;
                    wrAddr = cellAddr(curRow, cursorX_q - COL_W'(1));
                end
            end
        endcase
    end

    // Write-side control: sweeps, cursor movement and scrolling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR_ALL;
            cursorX_q <= '0;
            cursorY_q <= '0;
            top_q     <= '0;
            sweep_q   <= '0;
            rowBase_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            scroll_q  <= 1'b0;
        end else begin
            scroll_q <= 1'b0;
            case (state_q)
                ST_CLEAR_ALL, ST_CLEAR_ROW: begin
                    if ((state_q == ST_CLEAR_ALL && sweep_q == ADDR_W'(CELLS - 1)) ||
                        (state_q == ST_CLEAR_ROW && sweep_q == ADDR_W'(COLS - 1))) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        sweep_q <= sweep_q + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        if (isFF) begin
                            cursorX_q <= '0;
                            cursorY_q <= '0;
                            top_q     <= '0;
                            sweep_q   <= '0;
                            state_q   <= ST_CLEAR_ALL;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                        end else begin
                            if (isPrint) begin
                                cursorX_q <= lastCol ? '0 : cursorX_q + COL_W'(1);
                            end else if (isLF || isCR) begin
                                cursorX_q <= '0;
                            end else if (isBS && cursorX_q != '0) begin
                                cursorX_q <= cursorX_q - COL_W'(1);
                            end
                            // At the bottom, the old top row becomes the new, blanked bottom row.
                            if (doNewline) begin
                                if (cursorY_q != ROW_W'(ROWS - 1)) begin
                                    cursorY_q <= cursorY_q + ROW_W'(1);
                                end else begin
                                    top_q     <= (top_q == ROW_W'(ROWS - 1)) ? '0 : top_q + ROW_W'(1);
                                    rowBase_q <= cellAddr(top_q, COL_W'(0));
                                    sweep_q   <= '0;
                                    scroll_q  <= 1'b1;
                                    state_q   <= ST_CLEAR_ROW;
                                    ready_q   <= 1'b0;
                                    busy_q    <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= ST_CLEAR_ALL;
            endcase
        end
    end

    assign rdOob  = (int'(rd_x) >= COLS) || (int'(rd_y) >= ROWS);
    assign rdAddr = rdOob ? '0 : cellAddr(physRow(rd_y, top_q), rd_x);

    always_ff @(posedge clk) begin
        if (reset) begin
            rdOob_q <= 1'b1;
        end else begin
            rdOob_q <= rdOob;
        end
    end

    text_cell_ram #(
        .DEPTH  (CELLS),
        .WIDTH  (CHAR_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wrEn),
        .waddr (wrAddr),
        .wdata (wrData),
        .raddr (rdAddr),
        .rdata (ramData)
    );

    assign rd_char        = rdOob_q ? BLANK : ramData;
    assign chr.char_ready = ready_q;
    assign cursor_x       = cursorX_q;
    assign cursor_y       = cursorY_q;
    assign busy           = busy_q;
    assign scroll_pulse   = scroll_q;

endmodule

// File: doc/text_console_buffer.md
Name: text_console_buffer

Overview:
Parametrised character-cell console buffer, COLS x ROWS cells, for the VGA text path. It replaces direct (x,y) pokes with a streaming character interface that has a valid/ready handshake and a hardware cursor. The write side interprets control codes, wraps lines and scrolls using a circular row offset. An independent registered read port serves the pixel/glyph pipeline in logical screen coordinates.

Parameters:
COLS, 80, columns per row (>=2)
ROWS, 25, rows per screen (>=2)
CHAR_W, 8, bits per stored character
BLANK, 8'h20, fill value for clear/scroll/backspace
COL_W, $clog2(COLS), derived column index width
ROW_W, $clog2(ROWS), derived row index width

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
char_valid  in  1  char_data offered
char_ready  out  1  buffer can accept a character this cycle
char_data  in  CHAR_W  ASCII character or control code
rd_x  in  COL_W  display read column (logical)
rd_y  in  ROW_W  display read row (logical, 0 = top of screen)
rd_char  out  CHAR_W  cell content, 1-cycle latency
cursor_x  out  COL_W  current cursor column
cursor_y  out  ROW_W  current cursor row (logical)
busy  out  1  clear or scroll sweep in progress
scroll_pulse  out  1  one-cycle strobe when the screen scrolls by one row

Behaviour:
- Storage: single array of COLS*ROWS words. Physical row = (logical_row + top_row) mod ROWS. Address = phys_row*COLS + col. One write per cycle.
- Reset (synchronous, any state): cursor=(0,0), top_row=0, rd_char=BLANK, scroll_pulse=0, char_ready=0, busy=1, state=CLEAR_ALL.
- States: CLEAR_ALL, IDLE, CLEAR_ROW.
- CLEAR_ALL: writes BLANK to addresses 0..COLS*ROWS-1, one per cycle (COLS*ROWS cycles), then goes to IDLE.
- CLEAR_ROW: writes BLANK to the COLS cells of the target physical row (COLS cycles), then goes to IDLE.
- In both sweep states: char_ready=0, busy=1, and inputs are not consumed.
- IDLE: char_ready=1, busy=0. A transfer occurs when char_valid && char_ready. The effect is visible on cursor_x/cursor_y the next cycle.
- Codes accepted in IDLE:
  - Printable 0x20..0x7E: write to the cursor cell, then cursor_x+1. If cursor_x was COLS-1, cursor_x=0 and a newline is performed.
  - 0x0A LF: cursor_x=0, then newline (LF implies CR).
  - 0x0D CR: cursor_x=0 only.
  - 0x08 BS: if cursor_x>0, cursor_x-1 and BLANK is written at the new position. At column 0 it is a no-op; it never wraps to the previous row.
  - 0x0C FF: cursor=(0,0), top_row=0, enter CLEAR_ALL.
  - All other codes (0x00-0x1F not listed, 0x7F, >=0x80): consumed and ignored, no write.
- Newline:
  - If cursor_y<ROWS-1: cursor_y+1.
  - Otherwise: cursor_y stays ROWS-1, top_row=(top_row+1) mod ROWS, scroll_pulse=1 for one cycle, enter CLEAR_ROW targeting the old top_row's physical row (the new bottom row).
- Read port:
  - rd_char <= cell(rd_x, rd_y) on every posedge, in all states.
  - Mapping uses the top_row value current at that edge.
  - Same-cycle write to the same cell: read returns the old data (read-before-write).
  - rd_x>=COLS or rd_y>=ROWS returns BLANK.
  - During sweeps, partially cleared content is visible; this is accepted.
- Throughput: one character per cycle in IDLE, except codes that trigger a sweep.

Decomposition:
- Shared package console_pkg holds control-code constants (CC_LF, CC_CR, CC_BS, CC_FF), printable range bounds, and the state enum.
- One sub-module, text_cell_ram: simple dual-port RAM (1 write, 1 registered read), depth and width parameters, no reset on the array. This lets synthesis infer BRAM.

Test Plan:
- Reset, then wait COLS*ROWS cycles -> char_ready rises exactly then. Read any cell -> 8'h20. Cursor=(0,0).
- Stream "AB" -> cursor=(2,0). Read (0,0)=0x41 and (1,0)=0x42 one cycle after addressing.
- 80 printable characters from (0,0) -> cursor=(0,1) with no scroll. Read (79,0)=last character.
- Fill to cursor_y=24, then send LF -> scroll_pulse for 1 cycle, char_ready low for exactly 80 cycles. Logical row 0 shows the old row 1. Row 24 is all 0x20. Cursor=(0,24).
- BS at (0,3) -> no change. BS at (5,3) -> cursor=(4,3) and cell (4,3)=0x20. 0x07 -> ignored, cursor unchanged.
- Assert reset mid-CLEAR_ROW, and separately send FF -> CLEAR_ALL restarts, top_row=0, cursor=(0,0), all cells 0x20 afterwards.
